// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Brief    : Shared types and helpers for the staged reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    typedef enum logic [2:0] {
        S_BUS_WAIT     = 3'd0,
        S_PERIPH_WAIT  = 3'd1,
        S_MEMINIT_REQ  = 3'd2,
        S_MEMINIT_WAIT = 3'd3,
        S_CPU_WAIT     = 3'd4,
        S_RUN          = 3'd5,
        S_WARM_HOLD    = 3'd6
    } rst_seq_state_e;

    typedef enum logic [1:0] {
        POR = 2'b00,
        SW  = 2'b01,
        WDT = 2'b10
    } rst_cause_e;

    // One spare bit above the largest load value; the counter saturates at 0.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Brief    : Staged bus/peripheral/CPU reset release with memory-init gating
//            and warm-reset re-sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int STAGE_DELAY_p     = 16,
    parameter int SWRST_HOLD_p      = 32,
    parameter int MEMINIT_TIMEOUT_p = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_swrst_req,
    input  logic       i_wdt_bark,
    input  logic       i_meminit_done,
    output logic       o_bus_rst_n,
    output logic       o_periph_rst_n,
    output logic       o_cpu_rst_n,
    output logic       o_meminit_start,
    output logic [1:0] o_rst_cause,
    output logic       o_meminit_timeout,
    output logic       o_ready
);

    localparam int CW = cnt_width(STAGE_DELAY_p, SWRST_HOLD_p, MEMINIT_TIMEOUT_p);

    localparam logic [CW-1:0] c_stage_load   = CW'(STAGE_DELAY_p - 1);
    localparam logic [CW-1:0] c_hold_load    = CW'(SWRST_HOLD_p - 1);
    localparam logic [CW-1:0] c_meminit_load = CW'(MEMINIT_TIMEOUT_p - 1);

    rst_seq_state_e  state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            bus_q,    bus_d;
    logic            periph_q, periph_d;
    logic            cpu_q,    cpu_d;
    logic            start_q,  start_d;
    logic            tmo_q,    tmo_d;
    logic            ready_q,  ready_d;
    rst_cause_e      cause_q,  cause_d;
    logic            cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_BUS_WAIT;
            cnt_q    <= c_stage_load;
            bus_q    <= 1'b0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            start_q  <= 1'b0;
            tmo_q    <= 1'b0;
            ready_q  <= 1'b0;
            cause_q  <= POR;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            start_q  <= start_d;
            tmo_q    <= tmo_d;
            ready_q  <= ready_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_zero ? cnt_q : cnt_q - 1'b1;
        bus_d    = bus_q;
        periph_d = periph_q;
        cpu_d    = cpu_q;
        tmo_d    = tmo_q;
        ready_d  = ready_q;
        cause_d  = cause_q;
        // Registered copy of the request state: the pulse is visible while
        // the FSM sits in S_MEMINIT_WAIT's first cycle, one clock after entry.
        start_d  = (state_q == S_MEMINIT_REQ);

        case (state_q)
            S_BUS_WAIT: begin
                if (cnt_zero) begin
                    bus_d   = 1'b1;
                    state_d = S_PERIPH_WAIT;
                    cnt_d   = c_stage_load;
                end
            end
            S_PERIPH_WAIT: begin
                if (cnt_zero) begin
                    periph_d = 1'b1;
                    tmo_d    = 1'b0;
                    state_d  = S_MEMINIT_REQ;
                end
            end
            S_MEMINIT_REQ: begin
                state_d = S_MEMINIT_WAIT;
                cnt_d   = c_meminit_load;
            end
            S_MEMINIT_WAIT: begin
                // Done takes priority over a coincident timeout.
                if (i_meminit_done) begin
                    state_d = S_CPU_WAIT;
                    cnt_d   = c_stage_load;
                end else if (cnt_zero) begin
                    tmo_d   = 1'b1;
                    state_d = S_CPU_WAIT;
                    cnt_d   = c_stage_load;
                end
            end
            S_CPU_WAIT: begin
                if (cnt_zero) begin
                    cpu_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_wdt_bark || i_swrst_req) begin
                    cpu_d    = 1'b0;
                    periph_d = 1'b0;
                    ready_d  = 1'b0;
                    cause_d  = i_wdt_bark ? WDT : SW;
                    state_d  = S_WARM_HOLD;
                    cnt_d    = c_hold_load;
                end
            end
            S_WARM_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_PERIPH_WAIT;
                    cnt_d   = c_stage_load;
                end
            end
            default: begin
                state_d = S_BUS_WAIT;
                cnt_d   = c_stage_load;
            end
        endcase
    end

    assign o_bus_rst_n       = bus_q;
    assign o_periph_rst_n    = periph_q;
    assign o_cpu_rst_n       = cpu_q;
    assign o_meminit_start   = start_q;
    assign o_rst_cause       = cause_q;
    assign o_meminit_timeout = tmo_q;
    assign o_ready           = ready_q;

endmodule
`default_nettype wire

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Staged reset sequencer directly downstream of the clock/reset controller (ccr).
- Consumes ccr's debounced, PLL-lock-qualified reset and clock. Releases bus, peripheral and CPU resets in a fixed order, with a memory-init handshake gating the CPU release.
- Also handles warm resets: a software request or a watchdog bark re-asserts peripheral and CPU resets while the bus stays released, then re-runs the tail of the sequence.

Parameters:
- STAGE_DELAY_p, 16, cycles between consecutive release stages; must be >= 2.
- SWRST_HOLD_p, 32, cycles peripheral/CPU resets are held low on a warm reset; must be >= 2.
- MEMINIT_TIMEOUT_p, 4096, maximum cycles to wait for i_meminit_done before proceeding anyway.

Ports:
- i_clk  in  1  system clock (ccr o_clk).
- i_rst_n  in  1  asynchronous active-low reset (ccr o_rst_n); assertion is async, deassertion is already synchronous to i_clk.
- i_swrst_req  in  1  software reset request pulse (CSR write).
- i_wdt_bark  in  1  watchdog reset pulse.
- i_meminit_done  in  1  memory initialisation complete; level or pulse accepted.
- o_bus_rst_n  out  1  interconnect reset, active-low.
- o_periph_rst_n  out  1  peripheral reset, active-low.
- o_cpu_rst_n  out  1  CPU core reset, active-low.
- o_meminit_start  out  1  one-cycle pulse that starts memory init.
- o_rst_cause  out  2  last reset cause: 00 POR, 01 SW, 10 WDT; 11 is never driven.
- o_meminit_timeout  out  1  sticky flag: the last memory init timed out.
- o_ready  out  1  high only in S_RUN.

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n = 0:
  - all reset outputs are 0;
  - o_meminit_start = 0, o_ready = 0, o_meminit_timeout = 0;
  - o_rst_cause = 00;
  - state = S_BUS_WAIT;
  - counter loaded with STAGE_DELAY_p-1.
- All outputs are registered; no combinational path from any input to any output.
- One down-counter is shared by all states. It is loaded with N-1 on state entry, and the state exits on the edge where the count is 0. A wait of N therefore lasts exactly N cycles.
- Cycle numbering: cycle 0 is the first i_clk rising edge with i_rst_n = 1.
- FSM states:
  - S_BUS_WAIT: waits STAGE_DELAY_p cycles. On exit, o_bus_rst_n <= 1 (at edge STAGE_DELAY_p-1 with the default count), then go to S_PERIPH_WAIT.
  - S_PERIPH_WAIT: waits STAGE_DELAY_p cycles. On exit, o_periph_rst_n <= 1, then go to S_MEMINIT_REQ.
  - S_MEMINIT_REQ: lasts one cycle; o_meminit_start = 1. Go to S_MEMINIT_WAIT with the counter loaded to MEMINIT_TIMEOUT_p-1.
  - S_MEMINIT_WAIT, done: i_meminit_done = 1 goes to S_CPU_WAIT. i_meminit_done is ignored during S_MEMINIT_REQ.
  - S_MEMINIT_WAIT, timeout: counter reaches 0 with done still low. Set o_meminit_timeout and go to S_CPU_WAIT.
  - S_MEMINIT_WAIT, both on the same edge: done wins and the timeout flag is not set.
  - S_CPU_WAIT: waits STAGE_DELAY_p cycles. On exit, o_cpu_rst_n <= 1 and o_ready <= 1, then go to S_RUN.
  - S_RUN: i_wdt_bark or i_swrst_req goes to S_WARM_HOLD. On the next edge o_cpu_rst_n = 0, o_periph_rst_n = 0 and o_ready = 0. o_bus_rst_n stays 1.
  - S_WARM_HOLD: holds SWRST_HOLD_p cycles, then goes to S_PERIPH_WAIT.
- o_rst_cause on a warm reset: updated on entry to S_WARM_HOLD. If both requests arrive in the same cycle, WDT wins (10).
- Clearing o_meminit_timeout: it is cleared on entry to S_MEMINIT_REQ, so it reflects only the latest init.
- Requests outside S_RUN: i_swrst_req and i_wdt_bark are ignored. They are not queued.
- Reset mid-sequence: i_rst_n falling in any state gives an immediate async return to the reset values above, including o_rst_cause = 00.
- Counter width: $clog2 of the maximum of the three parameters, plus 1. No wrap is possible because the counter never decrements below 0.

Decomposition:
- Package rst_seq_pkg:
  - state enum rst_seq_state_e;
  - rst_cause_e with values POR = 2'b00, SW = 2'b01, WDT = 2'b10;
  - a constant function for counter width.
- No sub-module needed: a single FSM plus one counter. The wait counter may be factored as rst_seq_cnt if reused, but it stays inline by default.

Test Plan:
1. POR, default params, i_meminit_done tied high 5 cycles after o_meminit_start. Expected sequence:
   - o_bus_rst_n rises after 16 cycles;
   - o_periph_rst_n rises 16 cycles later;
   - o_meminit_start pulses one cycle later, width 1;
   - o_cpu_rst_n and o_ready rise 16 cycles after done is sampled;
   - o_rst_cause = 00 and o_meminit_timeout = 0.
2. i_meminit_done never asserted, MEMINIT_TIMEOUT_p = 64 -> o_meminit_timeout = 1 exactly 64 cycles after the start pulse; CPU released 16 cycles later.
3. In S_RUN, 1-cycle i_swrst_req -> next edge o_cpu_rst_n = o_periph_rst_n = 0 and o_bus_rst_n stays 1. Held 32 cycles; sequence re-runs from S_PERIPH_WAIT; o_rst_cause = 01.
4. In S_RUN, i_swrst_req and i_wdt_bark asserted in the same cycle -> o_rst_cause = 10 and a single warm sequence runs.
5. i_swrst_req pulsed during S_PERIPH_WAIT -> no effect; sequence timing identical to scenario 1.
6. i_rst_n dropped during S_MEMINIT_WAIT and during S_WARM_HOLD -> all outputs go to reset values asynchronously, with no clock edge needed. After release, the full POR sequence runs and o_rst_cause = 00.
